// File: rtl/moa_stream_feeder.sv
// -----------------------------------------------------------------------------
// moa_stream_feeder
//
// Streaming front/back end for the pipelined multi-operand adder.
// Operands arrive one per beat on a valid/ready stream. They are assembled into
// groups of N lanes, and each group is presented in parallel to the MOA for
// exactly one cycle. The MOA sum is captured LAT cycles later and returned
// through a small result FIFO, together with an 8-bit group tag that wraps.
//
// Credit rule: in_ready is high only while (results queued + groups in flight)
// is below DEPTH. Because of this, every issued group is guaranteed a FIFO slot
// and no result is ever dropped.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   feeder can accept an operand (registered)
//   in_data    operand, W bits
//   in_last    final operand of a short group; the remaining lanes are zeroed
//   moa_x      N lanes of W bits to the MOA; lane k = moa_x[k*W +: W]
//   moa_summ   MOA sum, valid LAT cycles after moa_x is driven
//   out_valid  result available (FIFO not empty)
//   out_ready  result consumer ready
//   out_sum    result sum at the FIFO head
//   out_tag    group sequence number of out_sum
//   busy       partial group, group in flight, or FIFO not empty
// -----------------------------------------------------------------------------
module moa_stream_feeder #(
    parameter int W     = 8,
    parameter int N     = 8,
    parameter int LAT   = 2,
    parameter int DEPTH = 4,
    parameter int SW    = W + $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic            in_last,
    output logic [N*W-1:0]  moa_x,
    input  logic [SW-1:0]   moa_summ,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_sum,
    output logic [7:0]      out_tag,
    output logic            busy
);

    localparam int IW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    // A group is counted as in flight from the edge that loads moa_x until the
    // edge that pushes its sum. This spans LAT+1 edges, so the counter must
    // hold values up to LAT+1.
    localparam int FW = $clog2(LAT + 2);

    // ---------------- state ----------------
    logic [IW-1:0]   idx_reg;
    logic [N*W-1:0]  lane_reg;
    logic [N*W-1:0]  moa_x_reg;
    logic [7:0]      tag_reg;
    logic            in_ready_reg;
    logic [LAT:0]    pipe_vld_reg;
    logic [7:0]      pipe_tag_reg [LAT+1];
    logic [FW-1:0]   inflight_count_reg;

    logic [SW-1:0]   fifo_sum_mem [DEPTH];
    logic [7:0]      fifo_tag_mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   fifo_count_reg;

    // ---------------- combinational control ----------------
    logic            accept;
    logic            complete;
    logic            push;
    logic            pop;
    logic [CW-1:0]   fifo_count_next;
    logic [FW-1:0]   inflight_count_next;
    logic [31:0]     credit_used;
    logic [N*W-1:0]  group_x;

    assign accept   = in_valid & in_ready_reg;
    assign complete = accept & (in_last | (idx_reg == IW'(N - 1)));
    // Stage LAT holds the group whose sum is on moa_summ in this cycle.
    assign push     = pipe_vld_reg[LAT];
    assign pop      = (fifo_count_reg != '0) & out_ready;

    always_comb begin
        fifo_count_next = fifo_count_reg;
        if (push && !pop) begin
            fifo_count_next = fifo_count_reg + CW'(1);
        end else if (!push && pop) begin
            fifo_count_next = fifo_count_reg - CW'(1);
        end
    end

    always_comb begin
        inflight_count_next = inflight_count_reg;
        if (complete && !push) begin
            inflight_count_next = inflight_count_reg + FW'(1);
        end else if (!complete && push) begin
            inflight_count_next = inflight_count_reg - FW'(1);
        end
    end

    assign credit_used = 32'(fifo_count_next) + 32'(inflight_count_next);

    // Assembled group as seen at the completing edge. Lanes below idx come
    // from storage, the current lane takes the operand on the bus, and the
    // lanes above are zero. A short group therefore pads with zeros.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign group_x[gi*W +: W] = (IW'(gi) <  idx_reg) ? lane_reg[gi*W +: W] :
                                        (IW'(gi) == idx_reg) ? in_data : '0;
        end
    endgenerate

    // ---------------- assembly, issue and in-flight tracking ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg            <= '0;
            lane_reg           <= '0;
            moa_x_reg          <= '0;
            tag_reg            <= '0;
            in_ready_reg       <= 1'b0;
            pipe_vld_reg       <= '0;
            inflight_count_reg <= '0;
            for (int i = 0; i <= LAT; i++) begin
                pipe_tag_reg[i] <= '0;
            end
        end else begin
            // Registered credit check. It uses the post-edge counts, so a
            // group issued on this edge is already counted.
            in_ready_reg       <= (credit_used < DEPTH[31:0]);
            inflight_count_reg <= inflight_count_next;
            pipe_vld_reg       <= {pipe_vld_reg[LAT-1:0], complete};
            pipe_tag_reg[0]    <= tag_reg;
            for (int i = 1; i <= LAT; i++) begin
                pipe_tag_reg[i] <= pipe_tag_reg[i-1];
            end

            for (int i = 0; i < N; i++) begin
                if (accept && (idx_reg == IW'(i))) begin
                    lane_reg[i*W +: W] <= in_data;
                end
            end

            if (complete) begin
                moa_x_reg <= group_x;
                idx_reg   <= '0;
                tag_reg   <= tag_reg + 8'd1;
            end else begin
                // The MOA sees zeros whenever no group is being issued.
                moa_x_reg <= '0;
                if (accept) begin
                    idx_reg <= idx_reg + IW'(1);
                end
            end
        end
    end

    // ---------------- result FIFO ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_sum_mem[i] <= '0;
                fifo_tag_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_sum_mem[wr_ptr_reg] <= moa_summ;
                fifo_tag_mem[wr_ptr_reg] <= pipe_tag_reg[LAT];
                wr_ptr_reg               <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            fifo_count_reg <= fifo_count_next;
        end
    end

    // The credit rule makes a push into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(push && (fifo_count_reg == CW'(DEPTH))));

    // ---------------- outputs ----------------
    assign in_ready  = in_ready_reg;
    assign moa_x     = moa_x_reg;
    assign out_valid = (fifo_count_reg != '0);
    assign out_sum   = fifo_sum_mem[rd_ptr_reg];
    assign out_tag   = fifo_tag_mem[rd_ptr_reg];
    assign busy      = (idx_reg != '0) | (inflight_count_reg != '0) | (fifo_count_reg != '0);

endmodule

// File: tb/tb_moa_stream_feeder.sv
// -----------------------------------------------------------------------------
// tb_moa_stream_feeder
// Directed bench for moa_stream_feeder, paired with a behavioural
// 2-cycle MOA model. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_moa_stream_feeder;

    localparam int W = 8;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic [63:0] moa_x;
    logic [10:0] moa_summ;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [10:0] out_sum;
    logic [7:0]  out_tag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    moa_stream_feeder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .moa_x     (moa_x),
        .moa_summ  (moa_summ),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    // Behavioural MOA: a sum of moa_x driven in cycle c appears on moa_summ in cycle c+2.
    logic [10:0] moa_s1 = 11'd0;
    logic [10:0] moa_s2 = 11'd0;
    always @(posedge clk) begin
        logic [10:0] acc;
        acc = 11'd0;
        for (int k = 0; k < N; k++) acc = acc + 11'(moa_x[k*W +: W]);
        moa_s1 <= acc;
        moa_s2 <= moa_s1;
    end
    assign moa_summ = moa_s2;

    // Expected results for the random back-to-back run.
    logic [10:0] exp_sum_q [$];
    logic [7:0]  exp_tag_q [$];

    // Present one beat and return on the falling edge after it is accepted.
    task automatic send_beat(input logic [7:0] d, input logic l);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_beat_timeout in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_group(input logic [7:0] vals [8], input int n, input logic use_last);
        for (int i = 0; i < n; i++) send_beat(vals[i], use_last && (i == n - 1));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle busy=%b required 0", busy);
        end
    endtask

    // Called on the falling edge right after the accepting edge. Checks that
    // out_valid is low for two more edges and rises on the third.
    task automatic check_result_latency(input string name, input logic [10:0] esum, input logic [7:0] etag);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_early k=%0d out_valid=%b required 0", name, k, out_valid);
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b1 || out_sum !== esum || out_tag !== etag) begin
            errors++;
            $display("FAIL %s_result valid=%b sum=%0d tag=%0d required valid=1 sum=%0d tag=%0d",
                     name, out_valid, out_sum, out_tag, esum, etag);
        end
        $display("result %s sum=%0d tag=%0d", name, out_sum, out_tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || moa_x !== 64'd0 || busy !== 1'b0 || out_sum !== 11'd0 || out_tag !== 8'd0) begin
            errors++;
            $display("FAIL reset_state out_valid=%b moa_x=%h busy=%b sum=%0d tag=%0d required all zero",
                     out_valid, moa_x, busy, out_sum, out_tag);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_stream();
        logic [7:0] v [8];
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) v[i] = 8'(i + 1);
        send_group(v, 8, 1'b0);
        checks++;
        if (moa_x !== 64'h0807060504030201) begin
            errors++;
            $display("FAIL stream_moa_x moa_x=%h required 0807060504030201", moa_x);
        end
        check_result_latency("stream", 11'd36, 8'd0);
        @(negedge clk);
        checks++;
        if (moa_x !== 64'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_after moa_x=%h out_valid=%b required 0 0", moa_x, out_valid);
        end
    endtask

    task automatic test_short_group();
        logic [7:0] v [8];
        for (int i = 0; i < 8; i++) v[i] = 8'd255;
        send_group(v, 3, 1'b1);
        checks++;
        if (moa_x !== 64'h0000000000FFFFFF) begin
            errors++;
            $display("FAIL short_moa_x moa_x=%h required 0000000000ffffff", moa_x);
        end
        check_result_latency("short", 11'd765, 8'd1);
        @(negedge clk);
    endtask

    task automatic test_max();
        logic [7:0] v [8];
        for (int i = 0; i < 8; i++) v[i] = 8'd255;
        send_group(v, 8, 1'b0);
        checks++;
        if (moa_x !== 64'hFFFFFFFFFFFFFFFF) begin
            errors++;
            $display("FAIL max_moa_x moa_x=%h required all ones", moa_x);
        end
        check_result_latency("max", 11'd2040, 8'd2);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int got;
        int cyc;
        logic [7:0] etag;
        got  = 0;
        cyc  = 0;
        etag = 8'd3;
        out_ready = 1'b1;
        fork
            begin
                logic [7:0]  v [8];
                logic [10:0] s;
                for (int g = 0; g < 300; g++) begin
                    s = 11'd0;
                    for (int i = 0; i < 8; i++) begin
                        v[i] = 8'($urandom_range(0, 255));
                        s = s + 11'(v[i]);
                    end
                    exp_sum_q.push_back(s);
                    exp_tag_q.push_back(etag);
                    etag = etag + 8'd1;
                    for (int i = 0; i < 8; i++) send_beat(v[i], 1'b0);
                end
                in_valid = 1'b0;
            end
            begin
                while (got < 300 && cyc < 4000) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid === 1'b1) begin
                        checks++;
                        if (exp_sum_q.size() == 0) begin
                            errors++;
                            $display("FAIL b2b_unexpected sum=%0d tag=%0d required no result", out_sum, out_tag);
                        end else begin
                            logic [10:0] es;
                            logic [7:0]  et;
                            es = exp_sum_q.pop_front();
                            et = exp_tag_q.pop_front();
                            if (out_sum !== es || out_tag !== et) begin
                                errors++;
                                $display("FAIL b2b_result n=%0d sum=%0d tag=%0d required sum=%0d tag=%0d",
                                         got, out_sum, out_tag, es, et);
                            end
                            $display("result b2b n=%0d sum=%0d tag=%0d", got, out_sum, out_tag);
                        end
                        got++;
                    end
                end
            end
        join
        checks++;
        if (got != 300) begin
            errors++;
            $display("FAIL b2b_count got=%0d required 300", got);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] v [8];
        wait_idle();
        out_ready = 1'b0;
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 8; i++) v[i] = 8'(g + 1);
            send_group(v, 8, 1'b0);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_drop in_ready=%b required 0", in_ready);
        end
        in_valid = 1'b1;
        in_data  = 8'd99;
        repeat (8) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_stalled in_ready=%b out_valid=%b busy=%b required 0 1 1", in_ready, out_valid, busy);
        end
        in_valid = 1'b0;
        // Tags: 3 single groups plus 300 random groups used tags 0..302, so the next tag is 303 mod 256 = 47.
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 11'(8 * (r + 1)) || out_tag !== 8'(47 + r)) begin
                errors++;
                $display("FAIL bp_drain r=%0d valid=%b sum=%0d tag=%0d required valid=1 sum=%0d tag=%0d",
                         r, out_valid, out_sum, out_tag, 8 * (r + 1), 47 + r);
            end
            $display("result bp r=%0d sum=%0d tag=%0d", r, out_sum, out_tag);
            out_ready = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_after out_valid=%b in_ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_mid_group();
        logic [7:0] v [8];
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) v[i] = 8'd50;
        send_group(v, 4, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_partial busy=%b required 1", busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || moa_x !== 64'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_in_reset busy=%b moa_x=%h out_valid=%b required 0 0 0", busy, moa_x, out_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_ready in_ready=%b required 1", in_ready);
        end
        for (int i = 0; i < 8; i++) v[i] = 8'(i + 1);
        send_group(v, 8, 1'b0);
        check_result_latency("rstmid", 11'd36, 8'd0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stale out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_short_group();
        test_max();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_group();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
